// File: rtl/redmule_ctx_sched.sv
// Purpose: tracks N_CONTEXT job slots (FREE/ACQUIRED/QUEUED/RUNNING) and dispatches them to the engine in commit order.
// Latency: grant is combinational; a commit into an idle scheduler gives start_o two cycles later; evt/err/abort pulse one cycle after their cause.
// Backpressure: acq_gnt_o drops while no slot is FREE; committed jobs wait in the FIFO while a job runs. Optional watchdog: REDMULE_SCHED_WATCHDOG_EN.
module redmule_ctx_sched #(
  parameter int unsigned N_CONTEXT      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic                                                  clear_i,
  input  logic                                                  acq_req_i,
  output logic                                                  acq_gnt_o,
  output logic [((N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1)-1:0]  acq_id_o,
  input  logic                                                  commit_i,
  input  logic [((N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1)-1:0]  commit_id_i,
  output logic                                                  err_o,
  output logic                                                  start_o,
  output logic [((N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1)-1:0]  start_id_o,
  input  logic                                                  done_i,
  output logic                                                  evt_o,
  output logic                                                  abort_o,
  output logic                                                  busy_o,
  output logic [((N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1):0]    n_free_o
);

  localparam int unsigned CtxW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;

  typedef enum logic [1:0] {FREE, ACQUIRED, QUEUED, RUNNING} slot_e;
  typedef enum logic [1:0] {IDLE, START, RUN} state_e;

  slot_e           slot_q [N_CONTEXT];
  state_e          state_q;
  logic [CtxW-1:0] fifo_q [N_CONTEXT];
  logic [CtxW-1:0] rd_ptr, wr_ptr;
  logic [CtxW:0]   fifo_cnt;

  logic            any_free;
  logic [CtxW-1:0] free_id;
  logic [CtxW:0]   n_free;
  logic            commit_ok;
  logic            push, pop;
  logic            timeout;
  logic            run_end;

  function automatic logic [CtxW-1:0] ptr_inc(input logic [CtxW-1:0] p);
    return (p == CtxW'(N_CONTEXT - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef REDMULE_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WdW-1:0] wd_cnt;
  logic           abort_q;
  assign timeout = (state_q == RUN) && !done_i && (wd_cnt == WdW'(TIMEOUT_CYCLES - 1));
  assign abort_o = abort_q;
`else
  assign timeout = 1'b0;
  assign abort_o = 1'b0;
`endif

  // Lowest-index free slot, free-slot count and legality of the incoming commit, all from registered slot state.
  always_comb begin
    any_free  = 1'b0;
    free_id   = '0;
    n_free    = '0;
    commit_ok = 1'b0;
    for (int i = N_CONTEXT - 1; i >= 0; i--) begin
      if (slot_q[i] == FREE) begin
        any_free = 1'b1;
        free_id  = CtxW'(i);
        n_free   = n_free + (CtxW + 1)'(1);
      end
      if (commit_i && commit_id_i == CtxW'(i) && slot_q[i] == ACQUIRED) begin
        commit_ok = 1'b1;
      end
    end
  end

  assign acq_gnt_o = acq_req_i && any_free && !clear_i;
  assign acq_id_o  = free_id;
  assign n_free_o  = n_free;
  assign busy_o    = (state_q != IDLE) || (fifo_cnt != '0);
  assign push      = commit_ok;
  assign pop       = (state_q == START);
  assign run_end   = (state_q == RUN) && (done_i || timeout);

  // Slot lifecycle, dispatch FIFO, dispatch FSM and registered pulse outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CONTEXT; i++) begin
        slot_q[i] <= FREE;
        fifo_q[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      state_q    <= IDLE;
      start_o    <= 1'b0;
      start_id_o <= '0;
      evt_o      <= 1'b0;
      err_o      <= 1'b0;
`ifdef REDMULE_SCHED_WATCHDOG_EN
      wd_cnt     <= '0;
      abort_q    <= 1'b0;
`endif
    end else if (clear_i) begin
      for (int i = 0; i < N_CONTEXT; i++) begin
        slot_q[i] <= FREE;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      state_q  <= IDLE;
      start_o  <= 1'b0;
      evt_o    <= 1'b0;
      err_o    <= 1'b0;
`ifdef REDMULE_SCHED_WATCHDOG_EN
      wd_cnt   <= '0;
      abort_q  <= 1'b0;
`endif
    end else begin
      start_o <= 1'b0;
      evt_o   <= 1'b0;
      err_o   <= commit_i && !commit_ok;
`ifdef REDMULE_SCHED_WATCHDOG_EN
      abort_q <= timeout;
`endif
      // Each event targets a slot in a distinct state, so these never collide on one slot.
      for (int i = 0; i < N_CONTEXT; i++) begin
        if (acq_gnt_o && acq_id_o == CtxW'(i))    slot_q[i] <= ACQUIRED;
        if (commit_ok && commit_id_i == CtxW'(i)) slot_q[i] <= QUEUED;
        if (pop && start_id_o == CtxW'(i))        slot_q[i] <= RUNNING;
        if (run_end && start_id_o == CtxW'(i))    slot_q[i] <= FREE;
      end
      if (push) begin
        fifo_q[wr_ptr] <= commit_id_i;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_cnt <= fifo_cnt + (CtxW + 1)'(push) - (CtxW + 1)'(pop);
      case (state_q)
        IDLE: begin
          if (fifo_cnt != '0) begin
            state_q    <= START;
            start_o    <= 1'b1;
            start_id_o <= fifo_q[rd_ptr];
          end
        end
        START: begin
          state_q <= RUN;
`ifdef REDMULE_SCHED_WATCHDOG_EN
          wd_cnt  <= '0;
`endif
        end
        RUN: begin
          if (done_i) begin
            state_q <= IDLE;
            evt_o   <= 1'b1;
          end else if (timeout) begin
            state_q <= IDLE;
          end
`ifdef REDMULE_SCHED_WATCHDOG_EN
          else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
